// File: rtl/maze_pkg.sv
// maze_pkg: shared MAZE mesh constants, packet type encodings and header layout.
package maze_pkg;
  localparam int DIR_N = 0;
  localparam int DIR_W = 1;
  localparam int DIR_S = 2;
  localparam int DIR_E = 3;
  localparam int DIR_B = 4;
  localparam int NDIR  = 5;
  typedef enum logic [1:0] {
    UNICAST   = 2'b00,
    COL_MCAST = 2'b01,
    ROW_MCAST = 2'b10,
    BCAST     = 2'b11
  } pkt_type_e;
  // Header offsets count upward from the first bit above the payload.
  localparam int COORD_W   = 3;
  localparam int TYPE_W    = 2;
  localparam int HDR_W     = TYPE_W + 4 * COORD_W;
  localparam int TGT_X_OFF = 0;
  localparam int TGT_Y_OFF = 3;
  localparam int SRC_X_OFF = 6;
  localparam int SRC_Y_OFF = 9;
  localparam int TYPE_OFF  = 12;
endpackage

// File: rtl/maze_fifo_sync.sv
// maze_fifo_sync: circular FIFO with occupancy counter; also exposes the entry behind the head.
module maze_fifo_sync #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             next_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full      = count == OW'(DEPTH);
  assign empty     = count == '0;
  assign next_data = mem[rd_ptr + AW'(1)];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push != pop) count <= push ? count + OW'(1) : count - OW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/maze_in_buf.sv
// maze_in_buf: per-direction input buffer; holds packets with route requests and tracks
// multicast fork progress so the head pops only once every requested output is served.
module maze_in_buf
  import maze_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 32,
  parameter int PKT_W     = HDR_W + PAYLOAD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PKT_W-1:0]       in_pkt,
  input  logic [NDIR-1:0]        in_route_req,
  output logic [NDIR-1:0]        out_req,
  input  logic [NDIR-1:0]        out_gnt,
  output logic [PKT_W-1:0]       out_pkt,
  output logic                   out_pop,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [7:0]             drop_cnt
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic [PKT_W+NDIR-1:0] next_data;
  logic [NDIR-1:0]       pend, g;
  logic                  full, empty, accept, push, drop, load_in, load_fifo;
  maze_fifo_sync #(.DEPTH(DEPTH), .W(PKT_W + NDIR)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (out_pop),
    .wdata     ({in_pkt, in_route_req}),
    .next_data (next_data),
    .count     (occupancy),
    .full      (full),
    .empty     (empty)
  );
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && |in_route_req;
  assign drop      = accept && ~|in_route_req;
  assign out_req   = pend & {NDIR{!empty}};
  assign g         = out_gnt & out_req;
  assign out_pop   = |g && ~|(pend & ~g);
  // The head register is refilled either from the entry behind it or straight from the link.
  assign load_fifo = out_pop && occupancy > OW'(1);
  assign load_in   = push && (empty || (out_pop && occupancy == OW'(1)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      out_pkt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (load_fifo) {out_pkt, pend} <= next_data;
      else if (load_in) {out_pkt, pend} <= {in_pkt, in_route_req};
      else pend <= out_pop ? '0 : pend & ~g;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
  a_no_req_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(occupancy == '0 && out_req != '0));
endmodule

// File: tb/tb_maze_in_buf.sv
// tb_maze_in_buf: vector table, corner-case sequences and random traffic against a queue model.
module tb_maze_in_buf;
  localparam int DEPTH = 4;
  localparam int PKT_W = 46;
  localparam int OW    = $clog2(DEPTH) + 1;
  logic             clk = 0, rst_n = 0, in_valid = 0, in_ready, out_pop;
  logic [PKT_W-1:0] in_pkt = '0, out_pkt;
  logic [4:0]       in_route_req = '0, out_req, out_gnt = '0;
  logic [OW-1:0]    occupancy;
  logic [7:0]       drop_cnt;
  int tests = 0, fails = 0;
  maze_in_buf #(.DEPTH(DEPTH), .PAYLOAD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .in_route_req(in_route_req), .out_req(out_req), .out_gnt(out_gnt), .out_pkt(out_pkt),
    .out_pop(out_pop), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic [4:0]       req;
  } ent_t;
  ent_t             q[$];
  logic [4:0]       served;
  int               drops;
  logic [PKT_W-1:0] last_pkt;
  typedef struct {
    logic             v;
    logic [PKT_W-1:0] pkt;
    logic [4:0]       req, gnt, exp_req;
    logic             exp_pop, exp_ready;
    int               exp_occ;
  } vec_t;
  vec_t vt[14];
  function automatic logic [PKT_W-1:0] mk(input logic [1:0] t, input logic [2:0] sy, sx, ty, tx,
                                          input logic [31:0] pl);
    return {t, sy, sx, ty, tx, pl};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] model_req();
    return q.size() > 0 ? q[0].req & ~served : 5'd0;
  endfunction
  task automatic model_clear();
    q.delete();
    served = '0;
    drops = 0;
    last_pkt = '0;
  endtask
  // Called at a negedge; drives one cycle, checks against the model, returns at the next negedge.
  task automatic step(input logic v, input logic [PKT_W-1:0] p, input logic [4:0] r, input logic [4:0] gn);
    logic [4:0] mreq, g;
    logic       mpop, acc;
    in_valid = v; in_pkt = p; in_route_req = r; out_gnt = gn;
    #1;
    mreq = model_req();
    g    = gn & mreq;
    mpop = g != 0 && (mreq & ~g) == 0;
    acc  = v && q.size() < DEPTH;
    chk("out_req", 64'(out_req), 64'(mreq));
    chk("out_pop", 64'(out_pop), 64'(mpop));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(drops));
    chk("out_pkt", 64'(out_pkt), 64'(q.size() > 0 ? q[0].pkt : last_pkt));
    @(posedge clk);
    if (mpop) begin
      void'(q.pop_front());
      served = '0;
    end else served |= g;
    if (acc) begin
      if (r != 0) q.push_back('{pkt: p, req: r});
      else if (drops < 255) drops++;
    end
    if (q.size() > 0) last_pkt = q[0].pkt;
    @(negedge clk);
  endtask
  task automatic do_reset();
    in_valid = 0; out_gnt = '0; in_route_req = '0;
    rst_n = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    logic [PKT_W-1:0] pa, pb, pc, pd;
    logic [4:0] rq;
    pa = mk(2'b00, 3'd1, 3'd1, 3'd3, 3'd2, 32'hA5A5_0001);
    pb = mk(2'b11, 3'd2, 3'd2, 3'd0, 3'd0, 32'hB0B0_0002);
    pc = mk(2'b00, 3'd0, 3'd4, 3'd5, 3'd5, 32'hCCCC_0003);
    pd = mk(2'b00, 3'd6, 3'd1, 3'd2, 3'd7, 32'hD00D_0004);
    vt[0]  = '{1, pa, 5'b01000, 5'b00000, 5'b00000, 0, 1, 0};
    vt[1]  = '{0, '0, 5'b00000, 5'b01000, 5'b01000, 1, 1, 1};
    vt[2]  = '{0, '0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0};
    vt[3]  = '{1, pb, 5'b11111, 5'b00000, 5'b00000, 0, 1, 0};
    vt[4]  = '{0, '0, 5'b00000, 5'b00011, 5'b11111, 0, 1, 1};
    vt[5]  = '{0, '0, 5'b00000, 5'b01000, 5'b11100, 0, 1, 1};
    vt[6]  = '{0, '0, 5'b00000, 5'b10100, 5'b10100, 1, 1, 1};
    vt[7]  = '{0, '0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0};
    vt[8]  = '{1, pc, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0};
    vt[9]  = '{1, pd, 5'b00001, 5'b00000, 5'b00000, 0, 1, 0};
    vt[10] = '{0, '0, 5'b00000, 5'b00110, 5'b00001, 0, 1, 1};
    vt[11] = '{0, '0, 5'b00000, 5'b00110, 5'b00001, 0, 1, 1};
    vt[12] = '{0, '0, 5'b00000, 5'b00001, 5'b00001, 1, 1, 1};
    vt[13] = '{0, '0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0};
    model_clear();
    @(negedge clk);
    #1;
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_pkt", 64'(out_pkt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_out_pop", 64'(out_pop), 64'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 14; i++) begin
      in_valid = vt[i].v; in_pkt = vt[i].pkt; in_route_req = vt[i].req; out_gnt = vt[i].gnt;
      #1;
      chk($sformatf("vec%0d_req", i), 64'(out_req), 64'(vt[i].exp_req));
      chk($sformatf("vec%0d_pop", i), 64'(out_pop), 64'(vt[i].exp_pop));
      chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vt[i].exp_occ));
      chk($sformatf("vec%0d_rdy", i), 64'(in_ready), 64'(vt[i].exp_ready));
      step(vt[i].v, vt[i].pkt, vt[i].req, vt[i].gnt);
    end
    chk("vec_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("vec_out_pkt_hold", 64'(out_pkt), 64'(pd));
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, mk(2'b01, 3'(i), 3'(i), 3'd1, 3'd1, 32'(i)), 5'(1 << (i % 5)) | 5'b10000, 5'b0);
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
    step(1, mk(2'b00, 3'd7, 3'd7, 3'd7, 3'd7, 32'hDEAD), 5'b00001, 5'b0);
    chk("ignored_push_occ", 64'(occupancy), 64'(DEPTH));
    step(0, '0, '0, 5'b10001);
    #1;
    chk("freed_in_ready", 64'(in_ready), 64'd1);
    chk("freed_occ", 64'(occupancy), 64'd3);
    step(0, '0, '0, 5'b10010);
    step(1, pa, 5'b00110, 5'b10100);
    #1;
    chk("concur_occ", 64'(occupancy), 64'd2);
    chk("concur_req", 64'(out_req), 64'(5'b11000));
    for (int i = 0; i < 4; i++) step(0, '0, '0, model_req());
    chk("drained_occ", 64'(occupancy), 64'd0);
    step(1, pb, 5'b11111, 5'b0);
    step(0, '0, '0, 5'b00101);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_req", 64'(out_req), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_rdy", 64'(in_ready), 64'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    step(1, pc, 5'b00100, 5'b0);
    step(0, '0, '0, 5'b00100);
    step(0, '0, '0, 5'b0);
    for (int i = 0; i < 260; i++) step(1, pd, 5'b0, 5'b0);
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    for (int i = 0; i < 400; i++) begin
      rq = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 3) != 0, {14'($urandom), 32'($urandom)}, rq,
           5'($urandom) | ($urandom_range(0, 1) ? model_req() : 5'd0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/maze_in_buf.md
Name: maze_in_buf

Overview:
- Per-direction input buffer of a MAZE mesh node. It sits directly downstream of the pre-buffer router, which supplies each arriving packet with a 5-bit route request [N,W,S,E,B].
- Stores the packet together with its route request in a FIFO.
- Presents the head packet's outstanding output requests to the switch allocator.
- Tracks multicast/broadcast fork progress: a multi-bit request may be granted over several cycles. The head pops only when every requested output has been served.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
PAYLOAD_W, 32, payload bits carried after header
PKT_W, 14+PAYLOAD_W, derived: {pkt_type[1:0], src_y, src_x, tgt_y, tgt_x (3b each), payload}

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream packet valid
in_ready  out  1  buffer can accept (= not full)
in_pkt  in  PKT_W  packet from link
in_route_req  in  5  route request from pre-router, bit order N=0,W=1,S=2,E=3,B=4
out_req  out  5  outstanding output requests of head packet
out_gnt  in  5  per-output grant from switch allocator
out_pkt  out  PKT_W  head packet data
out_pop  out  1  head fully served, popped this cycle
occupancy  out  $clog2(DEPTH)+1  stored entries
drop_cnt  out  8  saturating count of packets dropped with empty route request

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs 0, except in_ready=1.
  - Pointers, occupancy, pending mask and drop_cnt cleared.
  - Any stored packet is discarded; reset mid-operation flushes all state.
- Push:
  - in_valid & in_ready at a clock edge writes {in_pkt, in_route_req} into the tail.
  - in_ready = (occupancy != DEPTH). It is derived from registers only, with no combinational path from out_gnt.
  - A push while full is impossible by the handshake; in_valid without in_ready is ignored.
- Zero route request:
  - A packet accepted with in_route_req == 0 is not stored.
  - drop_cnt increments and saturates at 255.
- Head presentation:
  - Empty-to-non-empty latency is 1 cycle: a packet pushed at edge k drives out_req/out_pkt after edge k.
  - When empty, out_req = 0 and out_pkt holds its last value.
- Pending mask:
  - The 5-bit register `pend` loads the head entry's route request whenever a new entry becomes head.
  - out_req = pend & {5{!empty}}.
- Grant handling:
  - Effective grant g = out_gnt & out_req; grant bits outside out_req are ignored.
  - If g != 0 and (pend & ~g) == 0, out_pop=1 in that cycle (combinational). At the edge the head pops and pend loads the next entry's request, or 0 if none remains.
  - Otherwise pend <= pend & ~g. Partial multicast service is retained across cycles with no re-request of served outputs.
  - out_pkt is stable while the head is unchanged.
- Simultaneous push and pop:
  - Both take effect at the same edge; occupancy is unchanged.
  - Pushing into an empty buffer while out_pop=0 follows the latency rule above.
  - While full, a pop frees in_ready only in the next cycle.
- Pointer wrap: read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty are determined from occupancy.
- Invariant (assertion): out_req is never nonzero while occupancy == 0.

Decomposition:
- Package maze_pkg:
  - direction constants DIR_N=0, DIR_W=1, DIR_S=2, DIR_E=3, DIR_B=4
  - pkt_type encodings: UNICAST=00, COL_MCAST=01, ROW_MCAST=10, BCAST=11
  - header field offsets/widths within PKT_W
- Sub-module maze_fifo_sync (DEPTH, W): storage, pointers, occupancy, push/pop.
  - maze_in_buf instantiates it with W = PKT_W+5.
  - maze_in_buf adds the pend register, grant logic and drop counter.

Test Plan:
- Unicast: push pkt tgt=(3,2), req=5'b01000; grant E the next cycle -> out_pop=1 that cycle, occupancy back to 0, out_req=0 afterwards.
- Broadcast fork: push req=5'b11111; grant 5'b00011, then 5'b01000, then 5'b10100 -> out_req goes 11111 -> 11100 -> 10100 -> 00000; out_pop only on the third grant; out_pkt unchanged throughout.
- Full/backpressure: DEPTH=4, push 4 packets with no grants -> in_ready=0, 5th in_valid ignored; one pop -> in_ready=1 the next cycle; FIFO order preserved on drain.
- Concurrent push/pop at occupancy 2 -> occupancy stays 2; next head's out_req equals its stored route request.
- Zero request plus stray grant: push req=0 -> not stored, drop_cnt=1. With head req=5'b00001, out_gnt=5'b00110 -> no pop, pend unchanged.
- Reset mid-fork: after a partial grant, assert rst_n=0 asynchronously -> out_req=0, occupancy=0, in_ready=1 immediately; after release, a fresh push behaves normally.
